// File: rtl/serial_rec_rx.sv
// serial_rec_rx: serial frame receiver for the idle-high `rec` line from the
// source-select mux. It detects a start bit, centre-samples DATA_W data bits
// LSB first and checks the stop bit. It then presents the word with a
// one-cycle valid pulse, or pulses frame_err if the stop bit is bad.
// Optional feature: define SERIAL_RX_PARITY_EN to add one even-parity bit
// after the data bits and a parity_err output pulse.
module serial_rec_rx #(
   parameter int DATA_W  = 8,
   parameter int BIT_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rec,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              frame_err,
   output logic              busy
`ifdef SERIAL_RX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int HALF  = BIT_CYC / 2;
   localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // Start bit is sampled HALF cycles after the falling edge is seen, so
   // every later sample lands one full bit period later, mid-bit.
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              ferr_q, ferr_d;
`ifdef SERIAL_RX_PARITY_EN
   logic              par_q, par_d;
   logic              perr_q, perr_d;
`endif

   // Next-state, counters, shift register and the output pulses.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rec) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               // A high line at mid-start is a glitch, not a frame.
               state_d = rec ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               // Shift right with the new bit entering at the MSB, so the
               // first (LSB) bit ends up in bit 0 after DATA_W shifts.
               for (int i = 0; i < DATA_W - 1; i++) begin
                  shift_d[i] = shift_q[i+1];
               end
               shift_d[DATA_W-1] = rec;
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = rec;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               // Leave mid stop bit so a new start edge needs no gap.
               state_d = S_IDLE;
               if (rec) begin
`ifdef SERIAL_RX_PARITY_EN
                  if ((^shift_q) ^ par_q) begin
                     perr_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = shift_q;
                  valid_d = 1'b1;
`endif
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values, regardless of statement order.
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != S_IDLE);
`ifdef SERIAL_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_rec_rx.sv
// tb_serial_rec_rx: scoreboard bench for serial_rec_rx. Each frame sent
// pushes its expected pulse kind, data and arrival cycle; a negedge monitor
// pops and compares whenever the receiver pulses.
module tb_serial_rec_rx;

   localparam int DATA_W  = 8;
   localparam int BIT_CYC = 4;
   localparam int HALF    = BIT_CYC / 2;
`ifdef SERIAL_RX_PARITY_EN
   localparam int PAR_CYC = BIT_CYC;
`else
   localparam int PAR_CYC = 0;
`endif

   localparam logic [2:0] K_VALID = 3'b001;
   localparam logic [2:0] K_FERR  = 3'b010;
   localparam logic [2:0] K_PERR  = 3'b100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rec = 1'b1;
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              frame_err;
   logic              busy;
   logic              parity_err;

   serial_rec_rx #(
      .DATA_W (DATA_W),
      .BIT_CYC(BIT_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rec       (rec),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef SERIAL_RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

`ifndef SERIAL_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #5 clk = ~clk;

   // Count of rising edges so far; expected pulse times are in these units.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0]        kind;
      logic [DATA_W-1:0] data;
      int                cyc;
   } exp_t;

   exp_t              sb[$];
   logic [DATA_W-1:0] model_data;
   logic              busy_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the oldest expected event.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && (valid || frame_err || parity_err)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {29'd0, parity_err, frame_err, valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", {29'd0, parity_err, frame_err, valid}, {29'd0, e.kind});
            check("pulse_time", cyc, e.cyc);
            check("pulse_data", {24'd0, data}, {24'd0, e.data});
            check("busy_fall", {31'd0, busy}, 32'd0);
            check("busy_before", {31'd0, busy_prev}, 32'd1);
         end
      end
      busy_prev = busy;
   end

   // Hold the current line level for n rising edges, then step 1ns past the edge.
   task automatic hold(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // Send one frame starting just after a rising edge; the start bit is seen
   // at the next edge (E0) and the pulse is visible in the cycle after the
   // stop sample at E0 + HALF + (DATA_W+1)*BIT_CYC (+BIT_CYC with parity).
   task automatic send_frame(input logic [DATA_W-1:0] word, input logic par,
                             input logic stop, input int idle);
      exp_t e;
      e.cyc = cyc + 1 + HALF + (DATA_W + 1) * BIT_CYC + PAR_CYC;
      if (!stop) begin
         e.kind = K_FERR;
         e.data = model_data;
      end else if ((PAR_CYC != 0) && (((^word) ^ par) != 1'b0)) begin
         e.kind = K_PERR;
         e.data = model_data;
      end else begin
         e.kind     = K_VALID;
         e.data     = word;
         model_data = word;
      end
      sb.push_back(e);
      rec = 1'b0;
      hold(BIT_CYC);
      for (int k = 0; k < DATA_W; k++) begin
         rec = word[k];
         hold(BIT_CYC);
      end
`ifdef SERIAL_RX_PARITY_EN
      rec = par;
      hold(BIT_CYC);
`endif
      rec = stop;
      hold(BIT_CYC);
      rec = 1'b1;
      hold(idle);
   endtask

   initial begin
      rst        = 1'b1;
      rec        = 1'b1;
      model_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;

      // Idle line: nothing happens for 50 cycles.
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_data", {24'd0, data}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Single frame, then back-to-back frames with no gap.
      send_frame(8'hA5, ^8'hA5, 1'b1, 10);
      send_frame(8'h3C, ^8'h3C, 1'b1, 0);
      send_frame(8'hFF, ^8'hFF, 1'b1, 10);

      // Bad stop bit (line held low through the stop), then a good frame.
      send_frame(8'h55, ^8'h55, 1'b0, 12);
      send_frame(8'h0F, ^8'h0F, 1'b1, 10);

      // One-cycle glitch: enters START, then drops back to IDLE.
      rec = 1'b0;
      hold(1);
      rec = 1'b1;
      @(negedge clk);
      check("glitch_busy_hi", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      hold(1);
      @(negedge clk);
      check("glitch_busy_lo", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      hold(8);

      // Reset in the middle of the data bits of a 0x81 frame.
      rec = 1'b0;
      hold(BIT_CYC);
      rec = 1'b1;
      hold(BIT_CYC);
      rec = 1'b0;
      hold(BIT_CYC);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      hold(1);
      rst        = 1'b0;
      model_data = '0;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_data", {24'd0, data}, 32'd0);
      rec = 1'b1;
      hold(10);
      send_frame(8'h81, ^8'h81, 1'b1, 10);

`ifdef SERIAL_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 10);
      send_frame(8'h07, 1'b0, 1'b1, 10);
`endif

      // Let any outstanding pulses arrive, with a bounded wait.
      for (int i = 0; i < 200 && sb.size() > 0; i++) begin
         @(posedge clk);
      end
      hold(5);
      check("sb_drain", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_rec_rx.md
Name: serial_rec_rx

Overview:
Serial frame receiver placed directly downstream of the 2-to-1 source-select mux. It consumes the mux's single-bit `rec` line, which idles high. It detects a start bit, centre-samples DATA_W data bits LSB first and checks the stop bit. It then presents the parallel word with a one-cycle valid pulse, or flags a framing error.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- BIT_CYC, 4, clock cycles per serial bit (>=2). HALF = BIT_CYC/2 (integer division).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset.
- rec  input  1  serial line from the mux output; idle = 1. Already synchronous to clk.
- data  output  DATA_W  last good received word.
- valid  output  1  one-cycle pulse when `data` is updated.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst=1 at an edge forces IDLE, counters=0, shift reg=0, data=0, valid=0, frame_err=0, busy=0.
  - Reset mid-frame aborts the frame. No valid or error pulse follows.
- States: IDLE, START, DATA, STOP. A bit counter `cnt` counts 0..BIT_CYC-1. A bit index `idx` counts 0..DATA_W-1.
- IDLE:
  - rec=0 at edge E0 → START, cnt=0.
  - rec=1 → stay in IDLE.
- START:
  - Count HALF cycles, then sample rec.
  - rec=0 → DATA, cnt=0, idx=0.
  - rec=1 → false start (glitch); return to IDLE with no pulse.
- DATA:
  - When cnt reaches BIT_CYC-1, sample rec and shift it in at the MSB (shift right), so the first bit lands in bit 0 after DATA_W shifts.
  - Increment idx. After the DATA_W-th sample → STOP, cnt=0.
- STOP: when cnt reaches BIT_CYC-1, sample rec.
  - rec=1: data <= shift reg, valid=1 for the next cycle.
  - rec=0: frame_err=1 for the next cycle; data holds its previous value.
  - In both cases → IDLE on the same edge.
- Timing: the stop sample occurs at edge E0 + HALF + (DATA_W+1)*BIT_CYC. valid/frame_err are high during the following cycle. For the defaults this is E0+38.
- busy=1 in START, DATA and STOP.
- valid and frame_err are never high together.
- Back-to-back frames: the receiver re-enters IDLE mid stop bit. A start edge arriving any time after that is accepted with no gap cycles required.
- Line stuck low (break): each frame ends in frame_err. IDLE then sees rec=0 and immediately starts a new frame. This repeats until rec returns high.
- Input changes between sample points are ignored; only the centre samples count.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits, sampled like a data bit in an extra PARITY state. The stop sample shifts by BIT_CYC (edge E0+42 for defaults).
  - Adds output port parity_err (1 bit, reset 0).
  - Good stop with parity mismatch (XOR of data bits and parity bit ≠ 0): parity_err pulses for one cycle, valid is suppressed, data is held.
  - Bad stop: frame_err only; parity_err stays 0.
- Undefined: no PARITY state and no parity_err port. Frame = start + DATA_W + stop.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, rec=1 for 50 cycles → data=0, valid, frame_err and busy stay 0 throughout.
- Single frame 0xA5 (defaults): rec=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 → valid pulses exactly once at E0+39, data=0xA5, busy falls at the same time.
- Back-to-back 0x3C then 0xFF with a start edge immediately after each stop bit → two valid pulses 40 cycles apart, data=0x3C then 0xFF, no frame_err.
- Frame error: send 0x55 with stop=0 → frame_err pulses once, valid stays 0, data keeps its prior value. A following good 0x0F frame → valid, data=0x0F.
- Glitch and reset: rec low for 1 cycle only → return to IDLE, no pulse. Assert rst mid-DATA of a 0x81 frame → busy=0 next cycle, no valid; the next clean 0x81 frame is received correctly.
- Parity build (SERIAL_RX_PARITY_EN): 0x07 with parity=1 → valid, data=0x07. 0x07 with parity=0 → parity_err pulses, valid stays 0.
